// File: rtl/stepmotor_phase_monitor.sv
// Passive monitor of a 4-wire half-step stepper coil bus: phase decode, step/direction,
// absolute position, floor tracking and sticky health flags. Optional glitch filter: STEP_MON_FILTER_EN.
module stepmotor_phase_monitor #(
  parameter int unsigned STEPS_PER_FLOOR = 11719,
  parameter int unsigned NUM_FLOORS      = 3,
  parameter int unsigned STALL_CYCLES    = 100000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  motorpin,
  input  logic        err_clr,
  output logic        step_pulse,
  output logic        step_dir,
  output logic [15:0] position,
  output logic [1:0]  floor,
  output logic        at_floor,
  output logic        moving,
  output logic        err_skip,
  output logic        err_illegal,
  output logic        err_range
);

  localparam int unsigned PIN_W   = 4;
  localparam int unsigned PH_W    = 3;
  localparam int unsigned POS_W   = 16;
  localparam int unsigned FLR_W   = 2;
  localparam int unsigned OFF_W   = $clog2(STEPS_PER_FLOOR);
  localparam int unsigned STALL_W = $clog2(STALL_CYCLES + 1);

  localparam logic [OFF_W-1:0] OFF_MAX = OFF_W'(STEPS_PER_FLOOR - 1);
  localparam logic [FLR_W-1:0] FLR_TOP = FLR_W'(NUM_FLOORS - 1);

  logic [PIN_W-1:0]   sync1, sync2, last_code;
  logic               ref_valid, ref_valid_n;
  logic [PH_W-1:0]    ref_idx, ref_idx_n;
  logic [OFF_W-1:0]   offset, offset_n;
  logic [FLR_W-1:0]   floor_n;
  logic [POS_W-1:0]   position_n;
  logic [STALL_W-1:0] stall_cnt;

  logic            stable_c, event_c, legal_c, zero_c;
  logic [PH_W-1:0] idx_c, delta_c;
  logic            fwd_c, rev_c, skip_ev_c, ill_ev_c, rng_ev_c, step_ok_c;
  logic            at_top_c, at_bot_c;

  // Two-flop synchronizer for the asynchronous coil bus
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= motorpin;
      sync2 <= sync1;
    end
  end

`ifdef STEP_MON_FILTER_EN
  logic [PIN_W-1:0] hist1, hist2;

  // Pattern must persist for three synchronized samples before it is trusted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist1 <= '0;
      hist2 <= '0;
    end else begin
      hist1 <= sync2;
      hist2 <= hist1;
    end
  end

  assign stable_c = (sync2 == hist1) && (hist1 == hist2);
`else
  assign stable_c = 1'b1;
`endif

  assign event_c = stable_c && (sync2 != last_code);

  always_comb begin
    legal_c = 1'b1;
    zero_c  = 1'b0;
    idx_c   = '0;
    case (sync2)
      4'b1000: idx_c = 3'd0;
      4'b1100: idx_c = 3'd1;
      4'b0100: idx_c = 3'd2;
      4'b0110: idx_c = 3'd3;
      4'b0010: idx_c = 3'd4;
      4'b0011: idx_c = 3'd5;
      4'b0001: idx_c = 3'd6;
      4'b1001: idx_c = 3'd7;
      4'b0000: begin
        legal_c = 1'b0;
        zero_c  = 1'b1;
      end
      default: legal_c = 1'b0;
    endcase
  end

  // Phase reference tracking and step classification
  always_comb begin
    ref_valid_n = ref_valid;
    ref_idx_n   = ref_idx;
    fwd_c       = 1'b0;
    rev_c       = 1'b0;
    skip_ev_c   = 1'b0;
    ill_ev_c    = 1'b0;
    delta_c     = idx_c - ref_idx;
    if (event_c) begin
      if (zero_c) begin
        ref_valid_n = 1'b0;
      end else if (!legal_c) begin
        ill_ev_c    = 1'b1;
        ref_valid_n = 1'b0;
      end else begin
        ref_valid_n = 1'b1;
        ref_idx_n   = idx_c;
        if (ref_valid) begin
          case (delta_c)
            3'd0:    ;
            3'd1:    fwd_c = 1'b1;
            3'd7:    rev_c = 1'b1;
            default: skip_ev_c = 1'b1;
          endcase
        end
      end
    end
  end

  // Saturating position update, no wrap at either end of travel
  always_comb begin
    at_top_c   = (floor == FLR_TOP) && (offset == '0);
    at_bot_c   = (floor == '0) && (offset == '0);
    step_ok_c  = (fwd_c && !at_top_c) || (rev_c && !at_bot_c);
    rng_ev_c   = (fwd_c && at_top_c) || (rev_c && at_bot_c);
    offset_n   = offset;
    floor_n    = floor;
    position_n = position;
    if (step_ok_c && fwd_c) begin
      position_n = position + POS_W'(1);
      if (offset == OFF_MAX) begin
        offset_n = '0;
        floor_n  = floor + FLR_W'(1);
      end else begin
        offset_n = offset + OFF_W'(1);
      end
    end else if (step_ok_c) begin
      position_n = position - POS_W'(1);
      if (offset == '0) begin
        offset_n = OFF_MAX;
        floor_n  = floor - FLR_W'(1);
      end else begin
        offset_n = offset - OFF_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_code   <= '0;
      ref_valid   <= 1'b0;
      ref_idx     <= '0;
      offset      <= '0;
      floor       <= '0;
      position    <= '0;
      at_floor    <= 1'b0;
      step_pulse  <= 1'b0;
      step_dir    <= 1'b0;
      moving      <= 1'b0;
      stall_cnt   <= '0;
      err_skip    <= 1'b0;
      err_illegal <= 1'b0;
      err_range   <= 1'b0;
    end else begin
      if (event_c) begin
        last_code <= sync2;
      end
      ref_valid  <= ref_valid_n;
      ref_idx    <= ref_idx_n;
      step_pulse <= step_ok_c;
      if (step_ok_c) begin
        step_dir <= rev_c;
        offset   <= offset_n;
        floor    <= floor_n;
        position <= position_n;
        at_floor <= (offset_n == '0);
      end
      // A new error event in the same cycle as err_clr keeps the flag set
      err_skip    <= skip_ev_c | (err_skip & ~err_clr);
      err_illegal <= ill_ev_c  | (err_illegal & ~err_clr);
      err_range   <= rng_ev_c  | (err_range & ~err_clr);
      if (step_ok_c) begin
        stall_cnt <= STALL_W'(STALL_CYCLES);
        moving    <= 1'b1;
      end else if (stall_cnt != '0) begin
        stall_cnt <= stall_cnt - STALL_W'(1);
        if (stall_cnt == STALL_W'(1)) begin
          moving <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_stepmotor_phase_monitor.sv
// Self-checking bench for stepmotor_phase_monitor: vector table with a scoreboard queue
// plus hand-written floor, range, stall, glitch and mid-motion reset sequences.
module tb_stepmotor_phase_monitor;

  localparam int SPF   = 16;
  localparam int NF    = 3;
  localparam int STALL = 50;
`ifdef STEP_MON_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  motorpin = 4'b0000;
  logic        err_clr = 1'b0;
  logic        step_pulse, step_dir, at_floor, moving;
  logic        err_skip, err_illegal, err_range;
  logic [15:0] position;
  logic [1:0]  floor;

  stepmotor_phase_monitor #(
    .STEPS_PER_FLOOR(SPF),
    .NUM_FLOORS     (NF),
    .STALL_CYCLES   (STALL)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .motorpin   (motorpin),
    .err_clr    (err_clr),
    .step_pulse (step_pulse),
    .step_dir   (step_dir),
    .position   (position),
    .floor      (floor),
    .at_floor   (at_floor),
    .moving     (moving),
    .err_skip   (err_skip),
    .err_illegal(err_illegal),
    .err_range  (err_range)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] pins;
    logic       clr;
    logic       pulse;
    logic       dir;
    int         pos;
    logic       skip;
    logic       ill;
    logic       rng;
  } rec_t;

  rec_t vec[$];
  rec_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  bit   stepped = 0;
  int   cur;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [3:0] pat(input int i);
    logic [3:0] p;
    case (((i % 8) + 8) % 8)
      0: p = 4'b1000;
      1: p = 4'b1100;
      2: p = 4'b0100;
      3: p = 4'b0110;
      4: p = 4'b0010;
      5: p = 4'b0011;
      6: p = 4'b0001;
      default: p = 4'b1001;
    endcase
    return p;
  endfunction

  function automatic rec_t mk(input logic [3:0] pins, input logic clr, input logic pulse,
                              input logic dir, input int pos, input logic skip,
                              input logic ill, input logic rng);
    rec_t r;
    r.pins = pins; r.clr = clr; r.pulse = pulse; r.dir = dir;
    r.pos = pos; r.skip = skip; r.ill = ill; r.rng = rng;
    return r;
  endfunction

  task automatic pulse_clr();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  // Drive one pattern, queue its expectation, compare when the DUT result is due
  task automatic apply(input rec_t r);
    rec_t e;
    if (r.clr) pulse_clr();
    @(negedge clk);
    motorpin = r.pins;
    sbq.push_back(r);
    repeat (LAT - 1) @(posedge clk);
    #1;
    chk("early_pulse", int'(step_pulse), 0);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    if (e.pulse) stepped = 1;
    chk("step_pulse", int'(step_pulse), int'(e.pulse));
    chk("step_dir", int'(step_dir), int'(e.dir));
    chk("position", int'(position), e.pos);
    chk("floor", int'(floor), e.pos / SPF);
    chk("at_floor", int'(at_floor), (stepped && (e.pos % SPF == 0)) ? 1 : 0);
    chk("err_skip", int'(err_skip), int'(e.skip));
    chk("err_illegal", int'(err_illegal), int'(e.ill));
    chk("err_range", int'(err_range), int'(e.rng));
    @(posedge clk);
    #1;
    chk("pulse_width", int'(step_pulse), 0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_pulse"}, int'(step_pulse), 0);
    chk({tag, "_dir"}, int'(step_dir), 0);
    chk({tag, "_position"}, int'(position), 0);
    chk({tag, "_floor"}, int'(floor), 0);
    chk({tag, "_at_floor"}, int'(at_floor), 0);
    chk({tag, "_moving"}, int'(moving), 0);
    chk({tag, "_errs"}, int'({err_skip, err_illegal, err_range}), 0);
  endtask

  initial begin
    int n;
    int pulses;
    bit seen;

    // Forward walk through all eight phases, reverse step, skip, illegal, silent reload
    vec.push_back(mk(4'b1000, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 8; k++) vec.push_back(mk(pat(k), 0, 1, 0, k, 0, 0, 0));
    vec.push_back(mk(4'b1001, 0, 1, 1, 7, 0, 0, 0));
    vec.push_back(mk(4'b0100, 0, 0, 1, 7, 1, 0, 0));
    vec.push_back(mk(4'b1111, 0, 0, 1, 7, 1, 1, 0));
    vec.push_back(mk(4'b1000, 0, 0, 1, 7, 1, 1, 0));
    vec.push_back(mk(4'b1100, 0, 1, 0, 8, 1, 1, 0));
    // err_clr, de-energise, reload, then reverse down to 0 and into the bottom limit
    vec.push_back(mk(4'b0000, 1, 0, 0, 8, 0, 0, 0));
    vec.push_back(mk(4'b1000, 0, 0, 0, 8, 0, 0, 0));
    for (int k = 1; k <= 8; k++) vec.push_back(mk(pat(-k), 0, 1, 1, 8 - k, 0, 0, 0));
    vec.push_back(mk(4'b1001, 0, 0, 1, 0, 0, 0, 1));

    repeat (3) @(negedge clk);
    chk_reset_state("rst_hold");
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk_reset_state("rst_idle");

    for (int i = 0; i < vec.size(); i++) apply(vec[i]);
    cur = 7;

    pulse_clr();
    #1;
    chk("range_clr", int'(err_range), 0);

    // Climb two full floors then hit the top limit
    for (int k = 1; k <= 2 * SPF; k++) begin
      cur = cur + 1;
      apply(mk(pat(cur), 0, 1, 0, k, 0, 0, 0));
    end
    cur = cur + 1;
    apply(mk(pat(cur), 0, 0, 0, 2 * SPF, 0, 0, 1));

    // One reverse step off the top, then measure moving's stall timeout
    cur = cur - 1;
    @(negedge clk);
    motorpin = pat(cur);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (step_pulse) seen = 1;
    end
    chk("stall_pulse_seen", int'(seen), 1);
    chk("stall_moving_set", int'(moving), 1);
    chk("stall_position", int'(position), 2 * SPF - 1);
    chk("stall_floor", int'(floor), 1);
    n = 0;
    while (moving && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("stall_cycles", n, STALL);

`ifdef STEP_MON_FILTER_EN
    // Two-cycle glitch to the next phase must be ignored
    @(negedge clk);
    motorpin = pat(cur + 1);
    repeat (2) @(negedge clk);
    motorpin = pat(cur);
    pulses = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (step_pulse) pulses++;
    end
    chk("glitch_pulses", pulses, 0);
    chk("glitch_position", int'(position), 2 * SPF - 1);
`else
    pulses = 0;
`endif

    // Asynchronous reset in the middle of a step
    @(negedge clk);
    motorpin = pat(cur - 1);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_state("rst_async");
    @(negedge clk);
    reset_n = 1'b1;
    stepped = 0;
    cur = cur - 1;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_reload_pulse", int'(step_pulse), 0);
    chk("rst_reload_position", int'(position), 0);
    cur = cur + 1;
    apply(mk(pat(cur), 0, 1, 0, 1, 0, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
